// File: rtl/rf_mode_pkg.sv
// Shared definitions for the RF path sequencer: mode codes, pin bit positions,
// the safe (all-off) control bits and the low-power pin word.
package rf_mode_pkg;

   localparam logic [2:0] MODE_LOW_POWER = 3'd0;
   localparam logic [2:0] MODE_BYPASS    = 3'd1;
   localparam logic [2:0] MODE_RX_LPF    = 3'd2;
   localparam logic [2:0] MODE_RX_HPF    = 3'd3;
   localparam logic [2:0] MODE_TX_LPF    = 3'd4;
   localparam logic [2:0] MODE_TX_HPF    = 3'd5;

   localparam int PIN_MIXER_EN    = 0;
   localparam int PIN_LNA_RX_SHDN = 1;
   localparam int PIN_LNA_TX_SHDN = 2;
   localparam int PIN_TR_VC2      = 3;
   localparam int PIN_TR_VC1_B    = 4;
   localparam int PIN_TR_VC1      = 5;
   localparam int PIN_RX_H_B      = 6;
   localparam int PIN_RX_H        = 7;

   // Both LNAs shut down, mixer disabled.
   localparam logic [2:0] SAFE_BITS = 3'b110;

   localparam logic [7:0] PINS_LOW_POWER = 8'h56;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHDN,
      ST_SWITCH
   } seq_state_t;

   // Keep the switch bits of a pin word, force the LNA/mixer controls off.
   function automatic logic [7:0] safe_pins(input logic [7:0] pins);
      return {pins[PIN_RX_H:PIN_TR_VC2], SAFE_BITS};
   endfunction

endpackage

// File: rtl/rf_mode_decode.sv
// Mode code to RF pin word lookup; flags the unused codes 6 and 7 as invalid.
module rf_mode_decode
   import rf_mode_pkg::*;
(
   input  logic [2:0] mode,
   output logic [7:0] pins,
   output logic       valid
);

   // Pure table lookup; invalid codes fall back to the low-power word.
   always_comb begin
      pins  = PINS_LOW_POWER;
      valid = 1'b1;
      case (mode)
         MODE_LOW_POWER: pins = PINS_LOW_POWER;
         MODE_BYPASS:    pins = 8'h66;
         MODE_RX_LPF:    pins = 8'h9D;
         MODE_RX_HPF:    pins = 8'h5D;
         MODE_TX_LPF:    pins = 8'h6B;
         MODE_TX_HPF:    pins = 8'hAB;
         default: begin
            pins  = PINS_LOW_POWER;
            valid = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/rf_path_sequencer.sv
// Break-before-make sequencer for the RF front-end pins. A mode change first
// shuts both LNAs and the mixer off, then moves the path switches, lets them
// settle, and finally enables the target LNA/mixer. One pending request slot
// (latest wins) absorbs requests that arrive while a sequence is running.
module rf_path_sequencer
   import rf_mode_pkg::*;
#(
   parameter int GUARD_CYC  = 8,
   parameter int SETTLE_CYC = 16,
   parameter int CNT_W      = 8
)(
   input  logic       i_sys_clk,
   input  logic       i_rst,
   input  logic       i_req_valid,
   input  logic [2:0] i_req_mode,
   input  logic       i_abort,
   output logic [7:0] o_rf_pins,
   output logic [2:0] o_cur_mode,
   output logic       o_busy,
   output logic       o_pending,
   output logic       o_done,
   output logic       o_err
);

   localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

   seq_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       target_mode;
   logic [7:0]       target_pins;
   logic [2:0]       pend_mode;
   logic [7:0]       pend_pins;

   logic [7:0]       req_pins;
   logic             req_ok;
   logic             req_take;
   logic             req_bad;
   logic [2:0]       sel_mode;
   logic [7:0]       sel_pins;

   rf_mode_decode u_decode (
      .mode  (i_req_mode),
      .pins  (req_pins),
      .valid (req_ok)
   );

   // Classify the incoming request and pick what IDLE would start next:
   // a fresh valid request beats the pending slot.
   always_comb begin
      req_take = i_req_valid && req_ok;
      req_bad  = i_req_valid && !req_ok;
      sel_mode = req_take ? i_req_mode : pend_mode;
      sel_pins = req_take ? req_pins   : pend_pins;
   end

   // Sequencer FSM with registered pin, status and pending-slot outputs.
   // Target/pending payload registers carry data only and need no reset.
   always_ff @(posedge i_sys_clk) begin
      if (i_rst || i_abort) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         o_rf_pins  <= PINS_LOW_POWER;
         o_cur_mode <= MODE_LOW_POWER;
         o_busy     <= 1'b0;
         o_pending  <= 1'b0;
         o_done     <= 1'b0;
         o_err      <= 1'b0;
      end else begin
         o_done <= 1'b0;
         o_err  <= req_bad;
         case (state)
            ST_IDLE: begin
               if (req_take || o_pending) begin
                  o_pending <= 1'b0;
                  if (sel_mode == o_cur_mode) begin
                     o_done <= 1'b1;
                  end else begin
                     target_mode <= sel_mode;
                     target_pins <= sel_pins;
                     state       <= ST_SHDN;
                     cnt         <= '0;
                     o_rf_pins   <= safe_pins(o_rf_pins);
                     o_busy      <= 1'b1;
                  end
               end
            end
            ST_SHDN: begin
               if (cnt == GUARD_LAST) begin
                  state     <= ST_SWITCH;
                  cnt       <= '0;
                  o_rf_pins <= safe_pins(target_pins);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_SWITCH: begin
               if (cnt == SETTLE_LAST) begin
                  state      <= ST_IDLE;
                  cnt        <= '0;
                  o_rf_pins  <= target_pins;
                  o_cur_mode <= target_mode;
                  o_done     <= 1'b1;
                  o_busy     <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
         // While a sequence runs, valid requests land in the pending slot.
         if (state != ST_IDLE && req_take) begin
            pend_mode <= i_req_mode;
            pend_pins <= req_pins;
            o_pending <= 1'b1;
         end
      end
   end

endmodule
